// File: rtl/spi_sel_slave.sv
// SPI mode-0 slave holding an analog-mux select word, oversampled in the clk domain.
// Write frames commit the select word on chip-select release; every frame shifts back {1, zeros, sel}.
module spi_sel_slave #(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] sel,
  output logic             sel_upd,
  output logic             frame_err,
  output logic             busy,
  output logic             dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_armed;

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [7:0]             r_rx;
  logic [6:0]             r_tx;
  logic                   r_miso;
  logic [WIDTH-1:0]       r_sel;
  logic                   r_sel_upd;
  logic                   r_frame_err;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic [7:0]             w_tx_word;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  // A falling chip select only counts once cs_n has been seen high after reset,
  // so a frame already in progress at reset release is never captured.
  assign w_cs_fall   = r_cs_d & ~w_cs_s & r_armed;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_tx_word   = 8'h80 | {{(8-WIDTH){1'b0}}, r_sel};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (r_fill[SYNC_STAGES-1] && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rx        <= 8'd0;
      r_tx        <= 7'd0;
      r_miso      <= 1'b0;
      r_sel       <= '0;
      r_sel_upd   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sel_upd   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state <= S_SHIFT;
            r_cnt   <= 4'd0;
            r_rx    <= 8'd0;
            r_tx    <= w_tx_word[6:0];
            r_miso  <= w_tx_word[7];
          end
        end
        S_SHIFT: begin
          // Chip-select release takes priority over a coincident sclk edge.
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
            if (r_cnt == 4'd8) begin
              if (r_rx[7]) begin
                r_sel     <= r_rx[WIDTH-1:0];
                r_sel_upd <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_rx <= {r_rx[6:0], w_mosi_s};
            if (r_cnt != 4'd15) begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (w_sclk_fall) begin
            r_tx   <= {r_tx[5:0], 1'b0};
            r_miso <= (r_cnt < 4'd8) ? r_tx[6] : 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso      = r_miso;
  assign sel       = r_sel;
  assign sel_upd   = r_sel_upd;
  assign frame_err = r_frame_err;
  assign busy      = ~w_cs_s;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_sel_slave.sv
// Bench for spi_sel_slave: pin-level SPI frames, a frame-level model of sel/pulses/miso,
// and a per-cycle compare process against that model.
module tb_spi_sel_slave;

  localparam int W    = 2;
  localparam int SYNC = 2;

  logic         clk;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [W-1:0] sel;
  logic         sel_upd;
  logic         frame_err;
  logic         busy;
  logic         dbg_state;

  spi_sel_slave #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .sel       (sel),
    .sel_upd   (sel_upd),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W-1:0]  model_sel = '0;
  logic [W-1:0]  exp_sel   = '0;
  logic [W-1:0]  nxt_sel   = '0;
  int            win       = 0;
  int            e_upd     = 0;
  int            e_err     = 0;
  int            got_upd   = 0;
  int            got_err   = 0;
  int            tot_upd   = 0;
  int            tot_err   = 0;
  int            cs_stable = 0;
  logic          cs_prev   = 1'b1;
  logic [15:0]   last_miso = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level rule: 8 bits with W=1 commits, 8 bits with W=0 is a read, anything else is an error.
  task automatic model_frame_end(input logic [15:0] bits, input int n, input logic aborted);
    if (aborted) begin
      e_upd = 0;
      e_err = 0;
    end else if (n == 8 && bits[7]) begin
      model_sel = bits[W-1:0];
      e_upd = 1;
      e_err = 0;
    end else if (n == 8) begin
      e_upd = 0;
      e_err = 0;
    end else begin
      e_upd = 0;
      e_err = 1;
    end
    nxt_sel = model_sel;
    got_upd = 0;
    got_err = 0;
    win     = SYNC + 3;
  endtask

  task automatic sclk_bit(input logic b, input logic exp_miso, input string name);
    mosi = b;
    #50;
    last_miso = {last_miso[14:0], miso};
    chk(name, miso, exp_miso);
    sclk = 1'b1;
    #50;
    sclk = 1'b0;
  endtask

  // driver: one frame of n bits, MSB first, miso checked against {1, zeros, sel}
  task automatic send_frame(input logic [15:0] bits, input int n);
    logic [7:0] tx;
    logic       e;
    tx = 8'h80 | 8'(model_sel);
    last_miso = '0;
    cs_n = 1'b0;
    #100;
    for (int i = n - 1; i >= 0; i--) begin
      int k;
      k = n - 1 - i;
      e = (k < 8) ? tx[7-k] : 1'b0;
      sclk_bit(bits[i], e, "miso_bit");
    end
    #50;
    cs_n = 1'b1;
    mosi = 1'b0;
    model_frame_end(bits, n, 1'b0);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = ~cs_n;
    if (!rst) begin
      cs_stable = 0;
      chk("rst_sel", sel, '0);
      chk("rst_sel_upd", sel_upd, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_miso", miso, 1'b0);
    end else begin
      if (cs_n !== cs_prev) cs_stable = 0;
      else if (cs_stable < 1000) cs_stable++;
      if (cs_stable >= SYNC + 2) begin
        chk("busy", busy, exp_busy);
        if (cs_n) chk("miso_idle", miso, 1'b0);
      end
      if (win > 0) begin
        got_upd += int'(sel_upd);
        got_err += int'(frame_err);
        win--;
        if (win == 0) begin
          chk("commit_sel", sel, nxt_sel);
          chk("commit_upd_count", got_upd, e_upd);
          chk("commit_err_count", got_err, e_err);
          exp_sel = nxt_sel;
        end
      end else begin
        chk("held_sel", sel, exp_sel);
        chk("quiet_sel_upd", sel_upd, 1'b0);
        chk("quiet_frame_err", frame_err, 1'b0);
      end
    end
    cs_prev = cs_n;
    tot_upd += int'(sel_upd);
    tot_err += int'(frame_err);
  end

  initial begin
    rst  = 1'b0;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #100;
    chk("idle_sel", sel, 2'b00);
    chk("idle_busy", busy, 1'b0);
    chk("idle_miso", miso, 1'b0);

    send_frame(16'h0082, 8);
    #200;
    chk("w82_sel", sel, 2'b10);
    chk("w82_upd_total", tot_upd, 1);

    send_frame(16'h0000, 8);
    #200;
    chk("read_miso_seq", last_miso[7:0], 8'b1000_0010);
    chk("read_sel", sel, 2'b10);
    chk("read_upd_total", tot_upd, 1);

    send_frame(16'h0013, 5);
    #200;
    send_frame(16'h0103, 9);
    #200;
    chk("badlen_sel", sel, 2'b10);
    chk("badlen_err_total", tot_err, 2);

    send_frame(16'h0081, 8);
    #40;
    send_frame(16'h0083, 8);
    #200;
    chk("b2b_sel", sel, 2'b11);
    chk("b2b_upd_total", tot_upd, 3);
    chk("b2b_second_miso", last_miso[7:0], 8'b1000_0001);

    // reset in the middle of a write frame, released with cs_n still low
    cs_n = 1'b0;
    #100;
    sclk_bit(1'b1, 1'b1, "abort_miso_pre");
    sclk_bit(1'b0, 1'b0, "abort_miso_pre");
    sclk_bit(1'b0, 1'b0, "abort_miso_pre");
    sclk_bit(1'b0, 1'b0, "abort_miso_pre");
    rst = 1'b0;
    model_sel = '0;
    exp_sel   = '0;
    win       = 0;
    #30;
    rst = 1'b1;
    #100;
    sclk_bit(1'b0, 1'b0, "abort_miso_post");
    sclk_bit(1'b0, 1'b0, "abort_miso_post");
    sclk_bit(1'b0, 1'b0, "abort_miso_post");
    sclk_bit(1'b1, 1'b0, "abort_miso_post");
    #50;
    cs_n = 1'b1;
    mosi = 1'b0;
    model_frame_end(16'h0081, 8, 1'b1);
    #200;
    chk("abort_sel", sel, 2'b00);
    chk("abort_upd_total", tot_upd, 3);
    chk("abort_err_total", tot_err, 2);

    send_frame(16'h0083, 8);
    #200;
    send_frame(16'h0000, 8);
    #200;
    chk("recover_sel", sel, 2'b11);
    chk("recover_miso_seq", last_miso[7:0], 8'b1000_0011);
    chk("recover_upd_total", tot_upd, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
